// File: rtl/softmax_frame_ctrl_if.sv
// ============================================================================
// Module     : softmax_frame_ctrl_if
// Description: Upstream write/launch, softmax handshake and result bundle
//              for softmax_frame_ctrl.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface softmax_frame_ctrl_if #(
    parameter int IDX_W  = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              frame_go;
    logic [IDX_W-1:0]  frame_label;
    logic              busy;
    logic              sm_start;
    logic [DATA_W-1:0] sm_input;
    logic [IDX_W-1:0]  sm_input_idx;
    logic              sm_in_ready;
    logic              sm_backprop_ctrl;
    logic              sm_out_ready;
    logic [IDX_W-1:0]  sm_max;
    logic              sm_out_received;
    logic              result_valid;
    logic [IDX_W-1:0]  result_class;
    logic              result_correct;
    logic [CNT_W-1:0]  frames_total;
    logic [CNT_W-1:0]  frames_correct;
    logic              timeout_err;

    modport slave (
        input  wr_en, wr_idx, wr_data, frame_go, frame_label,
        input  sm_in_ready, sm_out_ready, sm_max,
        output busy, sm_start, sm_input, sm_input_idx, sm_backprop_ctrl,
        output sm_out_received, result_valid, result_class, result_correct,
        output frames_total, frames_correct, timeout_err
    );

    modport master (
        output wr_en, wr_idx, wr_data, frame_go, frame_label,
        output sm_in_ready, sm_out_ready, sm_max,
        input  busy, sm_start, sm_input, sm_input_idx, sm_backprop_ctrl,
        input  sm_out_received, result_valid, result_class, result_correct,
        input  frames_total, frames_correct, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/softmax_frame_ctrl.sv
// ============================================================================
// Module     : softmax_frame_ctrl
// Description: Buffers one frame of logits, streams it into softmax, scores the
//              returned argmax against the label and keeps saturating tallies.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module softmax_frame_ctrl #(
    parameter int N_CLASSES = 5,
    parameter int IDX_W     = 3,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 255
) (
    input  wire logic           clk,
    input  wire logic           rst,
    softmax_frame_ctrl_if.slave bus
);
    localparam int               TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLASSES - 1);
    localparam logic [IDX_W-1:0] IDX_LIM  = IDX_W'(N_CLASSES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] buf_q [N_CLASSES];
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  label_q, label_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              timeout_q, timeout_d;
    logic              rvalid_q, rvalid_d;
    logic [IDX_W-1:0]  rclass_q, rclass_d;
    logic              rcorr_q, rcorr_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  correct_q, correct_d;
    logic              w_hit;

    // Frame buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.wr_en && bus.wr_idx < IDX_LIM)
            buf_q[bus.wr_idx] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            label_q   <= '0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rclass_q  <= '0;
            rcorr_q   <= 1'b0;
            total_q   <= '0;
            correct_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            label_q   <= label_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            rvalid_q  <= rvalid_d;
            rclass_q  <= rclass_d;
            rcorr_q   <= rcorr_d;
            total_q   <= total_d;
            correct_q <= correct_d;
        end
    end

    assign w_hit = (bus.sm_max == label_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        label_d   = label_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        rvalid_d  = 1'b0;
        rclass_d  = rclass_q;
        rcorr_d   = rcorr_q;
        total_d   = total_q;
        correct_d = correct_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_go) begin
                    label_d = bus.frame_label;
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.sm_in_ready) begin
                    if (idx_q == IDX_LAST) begin
                        to_cnt_d = '0;
                        state_d  = S_WAIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Result registers are loaded here so they are visible in the first ACK cycle.
                if (bus.sm_out_ready) begin
                    rvalid_d = 1'b1;
                    rclass_d = bus.sm_max;
                    rcorr_d  = w_hit;
                    if (total_q != '1)
                        total_d = total_q + 1'b1;
                    if (w_hit && correct_q != '1)
                        correct_d = correct_q + 1'b1;
                    state_d = S_ACK;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                if (!bus.sm_out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy             = (state_q != S_IDLE);
    assign bus.sm_start         = (state_q == S_ISSUE);
    assign bus.sm_input         = (state_q == S_ISSUE) ? buf_q[idx_q] : '0;
    assign bus.sm_input_idx     = (state_q == S_ISSUE) ? idx_q : '0;
    assign bus.sm_backprop_ctrl = 1'b0;
    assign bus.sm_out_received  = (state_q == S_ACK);
    assign bus.result_valid     = rvalid_q;
    assign bus.result_class     = rclass_q;
    assign bus.result_correct   = rcorr_q;
    assign bus.frames_total     = total_q;
    assign bus.frames_correct   = correct_q;
    assign bus.timeout_err      = timeout_q;
endmodule

`default_nettype wire

// File: tb/tb_softmax_frame_ctrl.sv
// ============================================================================
// Module     : tb_softmax_frame_ctrl
// Description: Directed self-checking bench for softmax_frame_ctrl.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_softmax_frame_ctrl;
    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    softmax_frame_ctrl_if #(.IDX_W(3), .DATA_W(32), .CNT_W(16)) bus ();

    softmax_frame_ctrl #(
        .N_CLASSES(5), .IDX_W(3), .DATA_W(32), .CNT_W(16), .TIMEOUT(255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = idx;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic go(input logic [2:0] label);
        bus.frame_go    = 1'b1;
        bus.frame_label = label;
        tick();
        bus.frame_go    = 1'b0;
    endtask

    // Launch a frame with in_ready held high and land in WAIT.
    task automatic run_to_wait(input logic [2:0] label);
        bus.sm_in_ready = 1'b1;
        go(label);
        for (int i = 0; i < 5; i++) tick();
    endtask

    logic [31:0] ref_buf [5];
    logic [8:0]  pat;
    int          exp_idx;
    int          n;
    int          n_rcv;
    int          n_rv;

    initial begin
        vecs = 0;
        errs = 0;
        ref_buf[0] = 32'h00F0; ref_buf[1] = 32'h01E0; ref_buf[2] = 32'h02D0;
        ref_buf[3] = 32'h03C0; ref_buf[4] = 32'h04B0;
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
        bus.frame_go = 1'b0; bus.frame_label = '0;
        bus.sm_in_ready = 1'b0; bus.sm_out_ready = 1'b0; bus.sm_max = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy",  bus.busy, 0);
        chk("rst_start", bus.sm_start, 0);
        chk("rst_rcv",   bus.sm_out_received, 0);
        chk("rst_total", bus.frames_total, 0);
        chk("rst_class", bus.result_class, 0);
        chk("rst_to",    bus.timeout_err, 0);
        chk("rst_bp",    bus.sm_backprop_ctrl, 0);

        // 1: basic frame, label 4, max 4
        for (int i = 0; i < 5; i++) wr(3'(i), ref_buf[i]);
        wr(3'd5, 32'hBAD0);
        bus.sm_in_ready = 1'b1;
        go(3'd4);
        for (int i = 0; i < 5; i++) begin
            chk("t1_start", bus.sm_start, 1);
            chk("t1_idx",   bus.sm_input_idx, i);
            chk("t1_data",  bus.sm_input, ref_buf[i]);
            tick();
        end
        chk("t1_start_off", bus.sm_start, 0);
        chk("t1_busy_wait", bus.busy, 1);
        bus.wr_en = 1'b1; bus.wr_idx = 3'd0; bus.wr_data = 32'hDEAD;
        bus.frame_go = 1'b1; bus.frame_label = 3'd1;
        tick();
        bus.wr_en = 1'b0; bus.frame_go = 1'b0;
        chk("t1_ignore_go", bus.sm_start, 0);
        bus.sm_out_ready = 1'b1; bus.sm_max = 3'd4;
        tick();
        bus.sm_out_ready = 1'b0;
        chk("t1_rv",    bus.result_valid, 1);
        chk("t1_class", bus.result_class, 4);
        chk("t1_corr",  bus.result_correct, 1);
        chk("t1_total", bus.frames_total, 1);
        chk("t1_ncorr", bus.frames_correct, 1);
        chk("t1_rcv",   bus.sm_out_received, 1);
        tick();
        chk("t1_idle", bus.busy, 0);
        chk("t1_rv_pulse", bus.result_valid, 0);
        chk("t1_class_hold", bus.result_class, 4);

        // out_ready in IDLE is ignored
        bus.sm_out_ready = 1'b1;
        tick();
        chk("idle_oready_rcv",  bus.sm_out_received, 0);
        chk("idle_oready_busy", bus.busy, 0);
        bus.sm_out_ready = 1'b0;

        // 2: stalled issue, buffer must be unchanged by the writes while busy
        pat = 9'b101101001;
        bus.sm_in_ready = 1'b0;
        go(3'd4);
        exp_idx = 0;
        for (int k = 0; k < 9; k++) begin
            bus.sm_in_ready = pat[k];
            chk("t2_start", bus.sm_start, 1);
            chk("t2_idx",   bus.sm_input_idx, exp_idx);
            chk("t2_data",  bus.sm_input, ref_buf[exp_idx]);
            tick();
            if (pat[k]) exp_idx++;
        end
        chk("t2_start_off", bus.sm_start, 0);
        bus.sm_out_ready = 1'b1; bus.sm_max = 3'd4;
        tick();
        bus.sm_out_ready = 1'b0;
        chk("t2_total", bus.frames_total, 2);
        chk("t2_ncorr", bus.frames_correct, 2);
        tick();

        // 4: wrong prediction
        run_to_wait(3'd2);
        bus.sm_out_ready = 1'b1; bus.sm_max = 3'd3;
        tick();
        bus.sm_out_ready = 1'b0;
        chk("t4_rv",    bus.result_valid, 1);
        chk("t4_class", bus.result_class, 3);
        chk("t4_corr",  bus.result_correct, 0);
        chk("t4_total", bus.frames_total, 3);
        chk("t4_ncorr", bus.frames_correct, 2);
        tick();

        // 5: out_ready held four cycles
        run_to_wait(3'd1);
        bus.sm_out_ready = 1'b1; bus.sm_max = 3'd1;
        n_rcv = 0; n_rv = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.sm_out_received) n_rcv++;
            if (bus.result_valid) n_rv++;
        end
        bus.sm_out_ready = 1'b0;
        tick();
        if (bus.sm_out_received) n_rcv++;
        if (bus.result_valid) n_rv++;
        chk("t5_rcv_cycles", n_rcv, 4);
        chk("t5_rv_pulses",  n_rv, 1);
        chk("t5_idle",  bus.busy, 0);
        chk("t5_total", bus.frames_total, 4);
        chk("t5_ncorr", bus.frames_correct, 3);

        // 3: timeout
        run_to_wait(3'd0);
        n = 0; n_rv = 0;
        while (bus.busy && n < 400) begin
            n++;
            if (bus.result_valid) n_rv++;
            tick();
        end
        chk("t3_wait_cycles", n, 255);
        chk("t3_to",    bus.timeout_err, 1);
        chk("t3_rv",    n_rv, 0);
        chk("t3_total", bus.frames_total, 4);
        chk("t3_ncorr", bus.frames_correct, 3);
        run_to_wait(3'd0);
        bus.sm_out_ready = 1'b1; bus.sm_max = 3'd0;
        tick();
        bus.sm_out_ready = 1'b0;
        chk("t3_next_total", bus.frames_total, 5);
        chk("t3_next_ncorr", bus.frames_correct, 4);
        chk("t3_to_sticky",  bus.timeout_err, 1);
        tick();

        // 6: reset mid-issue
        bus.sm_in_ready = 1'b1;
        go(3'd3);
        tick(); tick();
        chk("t6_idx2", bus.sm_input_idx, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy",  bus.busy, 0);
        chk("t6_start", bus.sm_start, 0);
        chk("t6_idx",   bus.sm_input_idx, 0);
        chk("t6_total", bus.frames_total, 0);
        chk("t6_to",    bus.timeout_err, 0);
        chk("t6_class", bus.result_class, 0);

        // Buffer survives reset; same-cycle write and launch uses the new value
        bus.wr_en = 1'b1; bus.wr_idx = 3'd0; bus.wr_data = 32'h1234;
        go(3'd0);
        bus.wr_en = 1'b0;
        chk("wrgo_data0", bus.sm_input, 32'h1234);
        tick();
        chk("keep_data1", bus.sm_input, ref_buf[1]);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

`default_nettype wire
